// File: rtl/alu_bist_seq.sv
// alu_bist_seq: built-in self-test sequencer for a 32-bit ALU.
// Walks a fixed 12-entry vector table (APPLY -> SETTLE -> CHECK per vector),
// counts result mismatches and records the first failing vector index.
// Optional feature macro: ALU_BIST_ZERO_CHECK_EN adds a Zero-flag comparison.
module alu_bist_seq #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  Operation,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  input  logic [31:0] ALUResult,
  input  logic        Zero,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_count,
  output logic [3:0]  fail_index
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam logic [3:0] LAST_IDX   = 4'd11;
  localparam logic [3:0] NO_FAIL    = 4'hF;
  localparam logic [3:0] SETTLE_END = 4'(SETTLE_CYCLES - 1);

  function automatic vec_t vec_lookup(input logic [3:0] i);
    vec_t v;
    v = '0;
    case (i)
      4'd0:  v = '{4'b0000, 32'd4, 32'd5, 32'd4};
      4'd1:  v = '{4'b0001, 32'd4, 32'd5, 32'd5};
      4'd2:  v = '{4'b0010, 32'd4, 32'd5, 32'd9};
      4'd3:  v = '{4'b0011, 32'd4, 32'd5, 32'd1};
      4'd4:  v = '{4'b0110, 32'd4, 32'd5, 32'hFFFF_FFFF};
      4'd5:  v = '{4'b0111, 32'd4, 32'd10, 32'h0000_1000};
      4'd6:  v = '{4'b1000, 32'd4, 32'd10, 32'd0};
      4'd7:  v = '{4'b1001, 32'h113C_2DE4, 32'hFB0B_4877, 32'd0};
      4'd8:  v = '{4'b1010, 32'h113C_2DE4, 32'hFB0B_4877, 32'd1};
      4'd9:  v = '{4'b1011, 32'hFB0B_4877, 32'd10, 32'hFFFE_C2D2};
      4'd10: v = '{4'b1100, 32'd4, 32'd5, 32'd0};
      4'd11: v = '{4'b1101, 32'd4, 32'd5, 32'd0};
      default: v = '0;
    endcase
    return v;
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_idx;
  logic [3:0]  w_next_idx;
  logic [3:0]  r_settle_cnt;
  logic [3:0]  r_fail_count;
  logic [3:0]  r_fail_index;
  logic        r_pass;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  vec_t        w_cur_vec;
  vec_t        w_next_vec;
  logic        w_mismatch;

  assign w_cur_vec  = vec_lookup(r_idx);
  assign w_next_vec = vec_lookup(w_next_idx);

`ifdef ALU_BIST_ZERO_CHECK_EN
  assign w_mismatch = (ALUResult != w_cur_vec.exp) ||
                      (Zero != (w_cur_vec.exp == 32'd0));
`else
  logic w_unused_zero;
  assign w_unused_zero = Zero;
  assign w_mismatch    = (ALUResult != w_cur_vec.exp);
`endif

  // Next-state and next-index selection; abort overrides every transition.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    if (abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_next_state = S_APPLY;
            w_next_idx   = '0;
          end
        end
        S_APPLY:  w_next_state = S_SETTLE;
        S_SETTLE: begin
          if (r_settle_cnt == SETTLE_END) w_next_state = S_CHECK;
        end
        S_CHECK: begin
          if (r_idx == LAST_IDX) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_APPLY;
            w_next_idx   = r_idx + 4'd1;
          end
        end
        S_DONE:   w_next_state = S_IDLE;
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

  // State, index and settle counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_settle_cnt <= '0;
    end else begin
      r_state      <= w_next_state;
      r_idx        <= w_next_idx;
      r_settle_cnt <= (r_state == S_SETTLE && !abort) ? r_settle_cnt + 4'd1 : '0;
    end
  end

  // Operand registers: loaded as APPLY is entered so the ALU sees them for
  // the whole APPLY/SETTLE/CHECK window, zeroed whenever the window ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_next_state == S_APPLY) begin
      r_op <= w_next_vec.op;
      r_a  <= w_next_vec.a;
      r_b  <= w_next_vec.b;
    end else if (w_next_state != S_SETTLE && w_next_state != S_CHECK) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end
  end

  // Result bookkeeping: cleared on accepted start, updated in CHECK and DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fail_count <= '0;
      r_fail_index <= NO_FAIL;
      r_pass       <= 1'b0;
    end else if (!abort) begin
      if (r_state == S_IDLE && start) begin
        r_fail_count <= '0;
        r_fail_index <= NO_FAIL;
        r_pass       <= 1'b0;
      end else if (r_state == S_CHECK && w_mismatch) begin
        if (r_fail_count != 4'hF) r_fail_count <= r_fail_count + 4'd1;
        if (r_fail_count == 4'd0) r_fail_index <= r_idx;
      end else if (r_state == S_DONE) begin
        r_pass <= (r_fail_count == 4'd0);
      end
    end
  end

  assign busy       = (r_state == S_APPLY) || (r_state == S_SETTLE) || (r_state == S_CHECK);
  assign done       = (r_state == S_DONE) && !abort;
  assign pass       = r_pass;
  assign fail_count = r_fail_count;
  assign fail_index = r_fail_index;
  assign Operation  = r_op;
  assign SrcA       = r_a;
  assign SrcB       = r_b;

endmodule

// File: tb/tb_alu_bist_seq.sv
// tb_alu_bist_seq: directed bench for alu_bist_seq with a behavioural ALU
// whose faults are selectable (correct, broken SRA, inverted, Zero stuck 1).
module tb_alu_bist_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        busy;
  logic        done;
  logic        pass;
  logic [3:0]  fail_count;
  logic [3:0]  fail_index;

  int n_checks = 0;
  int n_fail   = 0;
  int edges;
  bit seen_done;

  // 0 correct, 1 SRA returns 0, 2 every result inverted, 3 Zero forced 1
  int mode = 0;

  alu_bist_seq #(.SETTLE_CYCLES(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .Operation  (Operation),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_count (fail_count),
    .fail_index (fail_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] alu_good;

  always_comb begin
    alu_good = '0;
    case (Operation)
      4'b0000: alu_good = SrcA & SrcB;
      4'b0001: alu_good = SrcA | SrcB;
      4'b0010: alu_good = SrcA + SrcB;
      4'b0011: alu_good = SrcA ^ SrcB;
      4'b0110: alu_good = SrcA - SrcB;
      4'b0111: alu_good = SrcA << SrcB[4:0];
      4'b1000: alu_good = SrcA >> SrcB[4:0];
      4'b1001: alu_good = {31'd0, $signed(SrcA) < $signed(SrcB)};
      4'b1010: alu_good = {31'd0, SrcA < SrcB};
      4'b1011: alu_good = $unsigned($signed(SrcA) >>> SrcB[4:0]);
      4'b1100: alu_good = {31'd0, $signed(SrcA) >= $signed(SrcB)};
      4'b1101: alu_good = {31'd0, SrcA >= SrcB};
      default: alu_good = '0;
    endcase
  end

  always_comb begin
    ALUResult = alu_good;
    if (mode == 1 && Operation == 4'b1011) ALUResult = '0;
    if (mode == 2) ALUResult = ~alu_good;
    Zero = (mode == 3) ? 1'b1 : (ALUResult == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start and counts rising edges, the start-sampling edge being the
  // first, until done is seen; gives up after 100 edges.
  task automatic run_seq(output int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_fc", {28'd0, fail_count}, 32'd0);
    check("rst_fi", {28'd0, fail_index}, 32'hF);
    check("rst_op", {28'd0, Operation}, 32'd0);
    check("rst_a", SrcA, 32'd0);
    check("rst_b", SrcB, 32'd0);
    reset = 1'b1;
    tick();

    // First-vector operands appear in APPLY, second vector three edges on.
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("v0_busy", {31'd0, busy}, 32'd1);
    check("v0_op", {28'd0, Operation}, 32'd0);
    check("v0_a", SrcA, 32'd4);
    check("v0_b", SrcB, 32'd5);
    tick(); tick(); tick();
    check("v1_op", {28'd0, Operation}, 32'd1);
    repeat (40) tick();

    // Correct ALU: full pass.
    mode = 0;
    run_seq(edges);
    check("good_latency", edges, 32'd37);
    check("good_pass", {31'd0, pass}, 32'd0);
    tick();
    check("good_pass_after", {31'd0, pass}, 32'd1);
    check("good_done_pulse", {31'd0, done}, 32'd0);
    check("good_busy_end", {31'd0, busy}, 32'd0);
    check("good_op_idle", {28'd0, Operation}, 32'd0);
    check("good_fc", {28'd0, fail_count}, 32'd0);
    check("good_fi", {28'd0, fail_index}, 32'hF);
    repeat (3) tick();
    check("good_pass_hold", {31'd0, pass}, 32'd1);

    // SRA broken: single mismatch at vector 9.
    mode = 1;
    run_seq(edges);
    check("sra_latency", edges, 32'd37);
    tick();
    check("sra_pass", {31'd0, pass}, 32'd0);
    check("sra_fc", {28'd0, fail_count}, 32'd1);
    check("sra_fi", {28'd0, fail_index}, 32'd9);

    // Every result inverted: all twelve vectors mismatch.
    mode = 2;
    run_seq(edges);
    tick();
    check("inv_fc", {28'd0, fail_count}, 32'd12);
    check("inv_fi", {28'd0, fail_index}, 32'd0);
    check("inv_pass", {31'd0, pass}, 32'd0);

    // Zero stuck at 1 with correct results.
    mode = 3;
    run_seq(edges);
    tick();
`ifdef ALU_BIST_ZERO_CHECK_EN
    check("zero_fc", {28'd0, fail_count}, 32'd8);
    check("zero_fi", {28'd0, fail_index}, 32'd0);
    check("zero_pass", {31'd0, pass}, 32'd0);
`else
    check("zero_fc", {28'd0, fail_count}, 32'd0);
    check("zero_fi", {28'd0, fail_index}, 32'hF);
    check("zero_pass", {31'd0, pass}, 32'd1);
`endif

    // Abort in vector 5 SETTLE with inverted ALU: five vectors already failed.
    mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    check("ab_v5_op", {28'd0, Operation}, 32'h7);
    check("ab_v5_b", SrcB, 32'd10);
    check("ab_v5_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", {31'd0, busy}, 32'd0);
    check("ab_done", {31'd0, done}, 32'd0);
    check("ab_pass", {31'd0, pass}, 32'd0);
    check("ab_op", {28'd0, Operation}, 32'd0);
    check("ab_fc", {28'd0, fail_count}, 32'd5);
    check("ab_fi", {28'd0, fail_index}, 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    check("ab_no_done", {31'd0, seen_done}, 32'd0);
    mode = 0;
    run_seq(edges);
    check("ab_rerun_latency", edges, 32'd37);
    tick();
    check("ab_rerun_pass", {31'd0, pass}, 32'd1);
    check("ab_rerun_fc", {28'd0, fail_count}, 32'd0);

    // start held high through the run, then reset pulsed mid-CHECK of vector 2.
    mode = 2;
    start = 1'b1;
    tick();
    repeat (8) tick();
    check("hold_op", {28'd0, Operation}, 32'h2);
    check("hold_busy", {31'd0, busy}, 32'd1);
    check("hold_fc", {28'd0, fail_count}, 32'd2);
    #3;
    reset = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_pass", {31'd0, pass}, 32'd0);
    check("arst_fc", {28'd0, fail_count}, 32'd0);
    check("arst_fi", {28'd0, fail_index}, 32'hF);
    check("arst_op", {28'd0, Operation}, 32'd0);
    check("arst_a", SrcA, 32'd0);
    check("arst_b", SrcB, 32'd0);
    start = 1'b0;
    tick();
    reset = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      tick();
      if (done || busy) seen_done = 1'b1;
    end
    check("arst_idle", {31'd0, seen_done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
